// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, word address type and PC select encoding
package cpu_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef logic [ADDR_W-1:0] word_addr_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INCR = 2'd1,
        PC_LOAD = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - fetch unit bus: imem address/data, decode control and instruction output
interface ifetch_if #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
);
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_dout;
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;

    modport master (
        output imem_addr,
        input  imem_dout,
        input  stall,
        input  redirect,
        input  redirect_pc,
        output instr,
        output instr_pc,
        output instr_valid
    );

    modport slave (
        input  imem_addr,
        output imem_dout,
        output stall,
        output redirect,
        output redirect_pc,
        input  instr,
        input  instr_pc,
        input  instr_valid
    );
endinterface

// File: rtl/ifetch_pc_unit.sv
// rtl/ifetch_pc_unit.sv - program counter register with hold/increment/load select
module pc_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  pc_sel_e           i_sel,
    input  logic [ADDR_W-1:0] i_load_pc,
    output logic [ADDR_W-1:0] o_pc
);
    logic [ADDR_W-1:0] r_pc;

    // Increment relies on natural ADDR_W-bit overflow for the wrap to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            case (i_sel)
                PC_LOAD: r_pc <= i_load_pc;
                PC_INCR: r_pc <= r_pc + 1'b1;
                default: r_pc <= r_pc;
            endcase
        end
    end

    assign o_pc = r_pc;
endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch: drives imem address, tags returned words with PC, handles stall/redirect
module ifetch
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                DATA_W   = cpu_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input logic     clk,
    input logic     rst,
    ifetch_if.master bus
);
    logic [ADDR_W-1:0] w_pc;
    pc_sel_e           w_sel;
    logic [ADDR_W-1:0] r_ipc;
    logic              r_valid;
    logic              r_held;
    logic [DATA_W-1:0] r_hold;

    always_comb begin
        w_sel = PC_INCR;
        if (bus.redirect) begin
            w_sel = PC_LOAD;
        end else if (bus.stall) begin
            w_sel = PC_HOLD;
        end
    end

    pc_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk       (clk),
        .rst       (rst),
        .i_sel     (w_sel),
        .i_load_pc (bus.redirect_pc),
        .o_pc      (w_pc)
    );

    // imem_dout only lives for one cycle, so the first stalled cycle captures it
    // and later stalled cycles replay the captured copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ipc   <= '0;
            r_valid <= 1'b0;
            r_held  <= 1'b0;
            r_hold  <= '0;
        end else if (bus.redirect) begin
            r_valid <= 1'b0;
            r_held  <= 1'b0;
        end else if (bus.stall) begin
            if (!r_held) begin
                r_hold <= bus.imem_dout;
                r_held <= 1'b1;
            end
        end else begin
            r_ipc   <= w_pc;
            r_valid <= 1'b1;
            r_held  <= 1'b0;
        end
    end

    assign bus.imem_addr   = w_pc;
    assign bus.instr       = r_valid ? (r_held ? r_hold : bus.imem_dout) : '0;
    assign bus.instr_pc    = r_ipc;
    assign bus.instr_valid = r_valid;
endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit for the single-cycle-read instruction memory `imem`. It owns the program counter and drives `imem.addr`. It takes the synchronous-read data back from `imem.dout` and presents one instruction per cycle, tagged with its PC, to decode. It sits between `imem` and the CPU decode stage, and handles decode back-pressure (stall) and control-flow redirects (branch/jump).

## Interface
Parameters:
- `ADDR_W`, 10: word-address width; matches the `imem` depth of 1024 words.
- `DATA_W`, 32: instruction width.
- `RESET_PC`, 0: first word address fetched after reset.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `imem_addr`  out  ADDR_W: word address to `imem.addr`.
- `imem_dout`  in  DATA_W: from `imem.dout`; valid one cycle after the address is sampled.
- `stall`  in  1: decode not accepting; hold the current instruction and PC.
- `redirect`  in  1: load a new PC; squash in-flight fetch.
- `redirect_pc`  in  ADDR_W: target word address, sampled when `redirect`=1.
- `instr`  out  DATA_W: current instruction; 0 when `instr_valid`=0.
- `instr_pc`  out  ADDR_W: word address of `instr`.
- `instr_valid`  out  1: `instr`/`instr_pc` are meaningful.

## Operation
- State:
  - `pc_q`: next address to fetch.
  - `ipc_q`: PC of the data arriving at `imem_dout`.
  - `valid_q`: qualifies the current output.
  - `held_q`, `hold_q`: stall holding register.
- `imem_addr` = `pc_q`, registered with no combinational path from the inputs.
- Reset, asynchronous:
  - `pc_q`=RESET_PC, `ipc_q`=0, `valid_q`=0, `held_q`=0, `hold_q`=0.
  - Outputs during reset: `instr`=0, `instr_pc`=0, `instr_valid`=0, `imem_addr`=RESET_PC.
- Output mux:
  - `instr` = `valid_q` ? (`held_q` ? `hold_q` : `imem_dout`) : 0.
  - `instr_pc` = `ipc_q`.
  - `instr_valid` = `valid_q`.
- Per rising edge, by priority:
  1. `redirect`=1 (stall ignored):
     - `pc_q`←`redirect_pc`, `valid_q`←0, `held_q`←0.
     - The word read this edge (old PC) is squashed.
  2. `stall`=1:
     - `pc_q`, `ipc_q` and `valid_q` hold.
     - If `held_q`=0: `hold_q`←`imem_dout`, `held_q`←1.
     - If `held_q`=1: `hold_q` holds.
  3. Otherwise (advance):
     - `ipc_q`←`pc_q`, `pc_q`←`pc_q`+1, `valid_q`←1, `held_q`←0.
- PC arithmetic is modulo 2^ADDR_W: 1023+1 wraps to 0 with no flag.
- `redirect_pc` equal to the current `pc_q` is legal and behaves like any other redirect, including the bubble.
- Stall while `valid_q`=0: the PC still holds, and `instr` stays 0.

## Timing
- Fetch latency: an address driven in cycle t appears on `instr` in cycle t+1.
- Throughput: one instruction per cycle with no stall or redirect.
- After reset deassertion:
  - Cycle 0: `instr_valid`=0.
  - Cycle 1: `instr_valid`=1 with `instr_pc`=RESET_PC.
- Redirect asserted in cycle t:
  - Cycle t+1: `instr_valid`=0 (one bubble).
  - Cycle t+2: `instr` = mem[`redirect_pc`], `instr_pc`=`redirect_pc`.
- Stall asserted in cycles t..t+n-1:
  - `instr`/`instr_pc` stay constant from cycle t through t+n.
  - Cycle t+n+1 shows the next sequential instruction.
  - No instruction is lost or duplicated.
- Reset mid-stall or mid-redirect: all state is cleared immediately; the post-reset sequence restarts from RESET_PC.

## Structure
- Shared package `cpu_pkg`:
  - `ADDR_W`, `DATA_W`, `RESET_PC` constants.
  - A `word_addr_t` typedef, shared with `imem` and decode.
- Natural sub-module `pc_unit`: holds `pc_q`, with hold/increment/load select and modulo wrap.
- The holding register and output mux stay in `ifetch`.
- `imem` is external and instantiated alongside `ifetch` at CPU top level, never inside it.

## Test plan
Bench: `imem` preloaded with mem[i]=32'hA000_0000+i, `RESET_PC`=0.
1. Reset, then free run 6 cycles:
   - Cycle 0: `instr_valid`=0.
   - Cycles 1..5: `instr`=A000_0000..A000_0004, with `instr_pc`=0..4.
2. `stall` for 3 cycles while `instr_pc`=2:
   - `instr`=A000_0002 held 4 cycles.
   - Then A000_0003, A000_0004.
3. `redirect`=1 with `redirect_pc`=10'h200 while `instr_pc`=3:
   - One cycle `instr_valid`=0, `instr`=0.
   - Then A000_0200 with `instr_pc`=0x200, followed by 0x201.
4. `redirect` and `stall` together, `redirect_pc`=5:
   - Redirect wins: one bubble, then `instr_pc`=5.
   - The held word is dropped.
5. Wrap: redirect to 1022, free run:
   - `instr_pc` sequence 1022, 1023, 0, 1.
   - `instr`=A000_03FE, A000_03FF, A000_0000, A000_0001.
6. Assert `rst` mid-stall at `instr_pc`=7:
   - Outputs are 0 and invalid immediately, asynchronously.
   - After release, the cycle-0/cycle-1 sequence from RESET_PC repeats.
